hit_manager: RTL
================

Name: hit_manager

Overview:
- Frame-level collision controller for the game datapath.
- On each frame tick it snapshots the player and enemy/bullet positions, then time-shares one hitbox-overlap comparator across NUM_OBJ objects.
- It then applies damage, invincibility frames and the lives count, and raises game_over.
- Sits between the object position generators (moon, hecatia, bullets) and the score/display logic.

Parameters:
- NUM_OBJ, 4, number of objects scanned per frame (2..16).
- PLAYER_R, 8, player hitbox half-size in pixels.
- OBJ_R, 16, object hitbox half-size in pixels.
- LIVES, 3, lives loaded at reset (1..7).
- IFRAMES, 60, invincibility length in frame ticks after a hit (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- player_x  in  10  player centre x.
- player_y  in  10  player centre y.
- obj_x  in  10*NUM_OBJ  packed object centre x; object i occupies bits [10i+9:10i].
- obj_y  in  10*NUM_OBJ  packed object centre y, same packing as obj_x.
- obj_valid  in  NUM_OBJ  object i participates when its bit is 1.
- hit  out  1  one-cycle pulse when damage is applied.
- hit_idx  out  clog2(NUM_OBJ)  index of the damaging object; held until the next hit.
- lives  out  3  remaining lives.
- invincible  out  1  high while the invincibility counter is non-zero.
- busy  out  1  high while a scan is in progress.
- game_over  out  1  sticky; lives have reached 0.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State IDLE; lives=LIVES; inv_cnt=0.
  - hit=0, hit_idx=0, busy=0, game_over=0, snapshot registers cleared.
  - Reset overrides everything, including mid-scan and OVER.
- States: IDLE, SCAN, UPDATE, OVER.
- IDLE, frame_tick=1 at edge E0:
  - Latch player_x/y, obj_x/y and obj_valid into snapshot registers.
  - Set idx=0 and hit_found=0.
  - If inv_cnt>0, decrement it.
  - Go to SCAN; busy=1 from the cycle after E0.
- SCAN:
  - One object per cycle; object k is evaluated at edge E(k+1).
  - Overlap test: valid[k] AND |px-ox|<PLAYER_R+OBJ_R AND |py-oy|<PLAYER_R+OBJ_R.
  - The comparison is strict. Absolute differences are unsigned 10-bit, computed without modular wrap (0 vs 1023 gives 1023).
  - The threshold sum is 11-bit.
  - On first overlap: set hit_found=1, record idx, go to UPDATE (early exit).
  - When idx=NUM_OBJ-1 with no overlap: go to UPDATE.
  - Otherwise idx+1.
  - Lowest index wins if several objects overlap.
- UPDATE (one cycle):
  - If hit_found and inv_cnt==0:
    - lives-1; hit=1 for exactly the next cycle.
    - hit_idx updated.
    - inv_cnt=IFRAMES.
  - If hit_found and inv_cnt!=0: no pulse, no change.
  - Next state is OVER if lives reached 0 this cycle, else IDLE.
  - busy drops to 0 when IDLE is entered.
- Latency:
  - Hit on object k: hit high in the cycle after edge E(k+2).
  - Miss: busy spans NUM_OBJ+1 cycles.
- Invincibility:
  - invincible = (inv_cnt!=0).
  - After a hit, the next IFRAMES-1 accepted ticks are protected; the IFRAMES-th tick's scan can damage again.
- frame_tick while in SCAN or UPDATE:
  - Ignored (not queued).
  - Snapshots are never updated mid-scan.
- OVER:
  - game_over=1, busy=0, hit=0; frame_tick ignored; lives=0.
  - Exit only by rst.
- Boundary conditions:
  - lives never underflows.
  - obj_valid all zero means no hit.
  - Input changes after E0 do not affect the current scan.

Test Plan:
1. Reset, then tick with player (100,100), obj0 (130,130), obj1 (123,100), others invalid -> hit pulse 3 cycles after the tick edge, hit_idx=1, lives 3->2, invincible=1.
2. Player (100,100), obj0 (124,100) (dx=24, equal to threshold) and obj0 (76,76) -> no hit on either; busy high for NUM_OBJ+1=5 cycles each.
3. After the hit in scenario 1, keep obj1 overlapping on every tick -> lives stays 2 for 59 ticks; the 60th tick hits, lives=1.
4. Player (5,5), obj0 (1000,5) -> no hit (no wrap). Two objects overlapping (idx 2 and 3) -> hit_idx=2.
5. Three spaced hits from LIVES=3 -> lives reaches 0, game_over=1. Further ticks produce no busy and no hit; rst restores lives=3 and game_over=0.
6. frame_tick pulsed during SCAN -> ignored. rst asserted mid-SCAN with a pending overlap -> no hit pulse, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/hit_manager.sv
// Frame-level collision controller: snapshots positions on frame_tick, scans objects
// through one shared hitbox comparator, then applies damage, i-frames and lives.
module hit_manager #(
    parameter int NUM_OBJ  = 4,
    parameter int PLAYER_R = 8,
    parameter int OBJ_R    = 16,
    parameter int LIVES    = 3,
    parameter int IFRAMES  = 60,
    localparam int IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic [9:0]              player_x,
    input  logic [9:0]              player_y,
    input  logic [10*NUM_OBJ-1:0]   obj_x,
    input  logic [10*NUM_OBJ-1:0]   obj_y,
    input  logic [NUM_OBJ-1:0]      obj_valid,
    output logic                    hit,
    output logic [IDX_W-1:0]        hit_idx,
    output logic [2:0]              lives,
    output logic                    invincible,
    output logic                    busy,
    output logic                    game_over
);

    localparam logic [10:0]      THR      = 11'(PLAYER_R + OBJ_R);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);
    localparam logic [7:0]       IFR      = 8'(IFRAMES);
    localparam logic [2:0]       LIVES_I  = 3'(LIVES);

    typedef enum logic [1:0] {IDLE, SCAN, UPDATE, OVER} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    found_q, found_d;
    logic [9:0]              px_q, px_d, py_q, py_d;
    logic [10*NUM_OBJ-1:0]   ox_q, ox_d, oy_q, oy_d;
    logic [NUM_OBJ-1:0]      ov_q, ov_d;
    logic [2:0]              lives_q, lives_d;
    logic [7:0]              inv_q, inv_d;
    logic                    hit_q, hit_d;
    logic [IDX_W-1:0]        hit_idx_q, hit_idx_d;

    logic [9:0]              cur_ox, cur_oy;
    logic                    cur_v;
    logic                    overlap;

    // Plain magnitude difference: no modular wrap across the screen edge.
    function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        cur_ox = '0;
        cur_oy = '0;
        cur_v  = 1'b0;
        for (int k = 0; k < NUM_OBJ; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_ox = ox_q[10*k +: 10];
                cur_oy = oy_q[10*k +: 10];
                cur_v  = ov_q[k];
            end
        end
        overlap = cur_v
                  && ({1'b0, absdiff(px_q, cur_ox)} < THR)
                  && ({1'b0, absdiff(py_q, cur_oy)} < THR);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        found_d   = found_q;
        px_d      = px_q;
        py_d      = py_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        ov_d      = ov_q;
        lives_d   = lives_q;
        inv_d     = inv_q;
        hit_d     = 1'b0;
        hit_idx_d = hit_idx_q;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    px_d    = player_x;
                    py_d    = player_y;
                    ox_d    = obj_x;
                    oy_d    = obj_y;
                    ov_d    = obj_valid;
                    idx_d   = '0;
                    found_d = 1'b0;
                    if (inv_q != 8'd0) inv_d = inv_q - 8'd1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // idx_q is left on the overlapping object so UPDATE can report it.
                if (overlap) begin
                    found_d = 1'b1;
                    state_d = UPDATE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = UPDATE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            UPDATE: begin
                if (found_q && inv_q == 8'd0) begin
                    if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                    inv_d     = IFR;
                end
                state_d = (lives_d == 3'd0) ? OVER : IDLE;
            end
            OVER: state_d = OVER;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            found_q   <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            ov_q      <= '0;
            lives_q   <= LIVES_I;
            inv_q     <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            found_q   <= found_d;
            px_q      <= px_d;
            py_q      <= py_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            ov_q      <= ov_d;
            lives_q   <= lives_d;
            inv_q     <= inv_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    assign hit        = hit_q;
    assign hit_idx    = hit_idx_q;
    assign lives      = lives_q;
    assign invincible = (inv_q != 8'd0);
    assign busy       = (state_q == SCAN) || (state_q == UPDATE);
    assign game_over  = (state_q == OVER);

endmodule
